pll_rst_sequencer: RTL

//  Downstream companion of the 100 MHz/50 MHz PLL wrapper. Runs on the free-running
//  24 MHz reference clock. Drives the PLL reset, qualifies the asynchronous extlock
//  and releases a system reset only after lock has been stable. On loss of lock,

---
 rtl/pll_rst_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pll_rst_sequencer.sv
// -----------------------------------------------------------------------------
// pll_rst_sequencer
// Purpose : Runs on the free-running reference clock that also feeds the PLL.
//           It pulses the PLL reset, waits for a synchronised extlock, requires
//           lock to stay stable for a programmable time, and only then releases
//           the system reset. Lock loss, lock timeout or a soft request in RUN
//           restarts the whole sequence.
// Ports   : clk           reference clock (same net as PLL refclk)
//           rst_n         synchronous active-low reset
//           pll_extlock   PLL lock indicator, asynchronous to clk
//           soft_rst_req  single-cycle restart request, honoured only in RUN
//           pll_reset     PLL reset pin, active-high, registered
//           sys_rst_n     system reset, active-low, registered (refclk domain)
//           pll_locked    high only while in RUN, registered
//           retry_cnt     saturating count of lock timeouts since rst_n
//           lost_cnt      saturating lock-loss count (PLL_LOSS_CNT_EN only)
// Build   : define PLL_LOSS_CNT_EN to add the lost_cnt port and counter.
// -----------------------------------------------------------------------------
module pll_rst_sequencer #(
   parameter int CNT_W         = 20,
   parameter int RST_CYCLES    = 24,
   parameter int LOCK_TIMEOUT  = 240000,
   parameter int STABLE_CYCLES = 2400
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_extlock,
   input  logic       soft_rst_req,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       pll_locked,
   output logic [3:0] retry_cnt
`ifdef PLL_LOSS_CNT_EN
   ,
   output logic [7:0] lost_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   state_t           state_r;
   state_t           state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic             lock_meta_r;
   logic             lock_s;
   logic             retry_inc_s;

   // Two-flop synchroniser: the only place pll_extlock is sampled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_meta_r <= 1'b0;
         lock_s      <= 1'b0;
      end else begin
         lock_meta_r <= pll_extlock;
         lock_s      <= lock_meta_r;
      end
   end

   // Next-state logic; lock_s=0 always wins over completion or soft request.
   always_comb begin
      state_nx_s  = state_r;
      retry_inc_s = 1'b0;
      case (state_r)
         ST_PLL_RST: begin
            if (cnt_r == RST_LAST) state_nx_s = ST_WAIT_LOCK;
            else                   state_nx_s = ST_PLL_RST;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_nx_s = ST_STABLE;
            end else if (cnt_r == TIMEOUT_LAST) begin
               state_nx_s  = ST_PLL_RST;
               retry_inc_s = 1'b1;
            end else begin
               state_nx_s = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (!lock_s)                    state_nx_s = ST_WAIT_LOCK;
            else if (cnt_r == STABLE_LAST)  state_nx_s = ST_RUN;
            else                            state_nx_s = ST_STABLE;
         end
         ST_RUN: begin
            if (!lock_s || soft_rst_req) state_nx_s = ST_PLL_RST;
            else                         state_nx_s = ST_RUN;
         end
         default: begin
            state_nx_s = ST_PLL_RST;
         end
      endcase
   end

   // State register and shared counter; counter restarts on every state change
   // and is held at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_PLL_RST;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         if (state_nx_s != state_r) cnt_r <= {CNT_W{1'b0}};
         else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
         else                       cnt_r <= cnt_r;
      end
   end

   // Outputs are decoded from the next state so they change on the very edge
   // that enters or leaves a state, straight from flops (glitch-free).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pll_reset  <= 1'b1;
         sys_rst_n  <= 1'b0;
         pll_locked <= 1'b0;
      end else begin
         pll_reset  <= (state_nx_s == ST_PLL_RST);
         sys_rst_n  <= (state_nx_s == ST_RUN);
         pll_locked <= (state_nx_s == ST_RUN);
      end
   end

   // Lock-timeout retry counter, saturating at 15.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retry_cnt <= 4'd0;
      end else if (retry_inc_s && (retry_cnt != 4'hF)) begin
         retry_cnt <= retry_cnt + 4'd1;
      end else begin
         retry_cnt <= retry_cnt;
      end
   end

`ifdef PLL_LOSS_CNT_EN
   // Lock-loss counter: only a RUN exit caused by lock_s=0 counts, even when a
   // soft request arrives in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lost_cnt <= 8'd0;
      end else if ((state_r == ST_RUN) && !lock_s && (lost_cnt != 8'hFF)) begin
         lost_cnt <= lost_cnt + 8'd1;
      end else begin
         lost_cnt <= lost_cnt;
      end
   end
`endif

endmodule
